// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory load path.
// Holds the load size codes, the load FSM state encoding and a misalignment helper.
// Every load-path RTL file imports this package.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 is also decoded as a word

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // A halfword must sit on an even address and a word on a multiple of four.
    // Bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF)
            mis = offset[0];
        else if (size[1])
            mis = (offset != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Purpose: picks the addressed byte or halfword out of a big-endian word and extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows the inputs.
// Ports: word/offset/size/sign in, 32-bit extended result out.
module load_aligner
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Big-endian lanes: offset 0 is the most significant byte.
        byte_sel = word[31:24];
        case (offset)
            2'd0: byte_sel = word[31:24];
            2'd1: byte_sel = word[23:16];
            2'd2: byte_sel = word[15:8];
            2'd3: byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase

        // Only offset[1] picks the halfword; offset[0] is either trapped
        // upstream or deliberately ignored.
        half_sel = offset[1] ? word[15:0] : word[31:16];

        result = word;
        case (size)
            SZ_BYTE: result = {{24{sign & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{sign & half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Purpose: MIPS load unit; one word read per request, byte/half select and extend.
// Latency: request at edge 0 -> strobe in cycle 1 -> done pulse one cycle after ack (min 2 cycles).
// Backpressure: ready_port low while busy; requests are not queued, the memory strobe is held until ack.
// Ports: clk_port/rst_port (async active-low); req/ready/addr/size/sign request side;
//        mem_rd/mem_addr/mem_ack/mem_data memory side; q/done (and err) result side.
// Optional: MISALIGN_TRAP_EN adds err_port and completes misaligned loads without a memory access.
module mem_load_unit
    import mips_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int n  = 32      // must stay 32
) (
    input  logic          clk_port,
    input  logic          rst_port,
    input  logic          req_port,
    output logic          ready_port,
    input  logic [AW-1:0] addr_port,
    input  logic [1:0]    size_port,
    input  logic          sign_port,
    output logic          mem_rd_port,
    output logic [AW-1:0] mem_addr_port,
    input  logic          mem_ack_port,
    input  logic [n-1:0]  mem_data_port,
    output logic [n-1:0]  q_port,
`ifdef MISALIGN_TRAP_EN
    output logic          err_port,
`endif
    output logic          done_port
);

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic [31:0]   aligned;

    load_aligner u_aligner (
        .word   (mem_data_port),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .sign   (sign_q),
        .result (aligned)
    );

    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port) begin
            state  <= S_IDLE;
            addr_q <= '0;
            size_q <= '0;
            sign_q <= 1'b0;
            q_port <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_port) begin
                addr_q <= addr_port;
                size_q <= size_port;
                sign_q <= sign_port;
            end
            if (state == S_READ && mem_ack_port)
                q_port <= aligned;
        end
    end

    always_comb begin
        state_nxt     = state;
        ready_port    = 1'b0;
        mem_rd_port   = 1'b0;
        done_port     = 1'b0;
        mem_addr_port = {addr_q[AW-1:2], 2'b00};
        case (state)
            S_IDLE: begin
                ready_port = 1'b1;
                if (req_port) begin
`ifdef MISALIGN_TRAP_EN
                    state_nxt = is_misaligned(size_port, addr_port[1:0]) ? S_DONE : S_READ;
`else
                    state_nxt = S_READ;
`endif
                end
            end
            S_READ: begin
                // Strobe is a decode of the async-reset state, so reset drops it at once.
                mem_rd_port = 1'b1;
                if (mem_ack_port)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done_port = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Set on acceptance, so it is already valid during DONE; cleared leaving DONE.
    logic err_q;
    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port)
            err_q <= 1'b0;
        else if (state == S_IDLE && req_port)
            err_q <= is_misaligned(size_port, addr_port[1:0]);
        else if (state == S_DONE)
            err_q <= 1'b0;
    end
    assign err_port = err_q;
`endif

endmodule
